// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=4 convolutional encoder feeding the Viterbi link. It frames FRAME_LEN
// information bits, appends three zero tail bits and drives a single-entry symbol register.
module conv_encoder_tx #(
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(2);

  state_t           state, state_n;
  logic [2:0]       sr, sr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sym_n;
  logic             sym_valid_n;
  logic             done_n;
  logic             slot_free;
  logic             load;
  logic             u;

  assign slot_free = !sym_valid || sym_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    sym_n       = sym;
    // an accepted symbol without a replacement empties the register
    sym_valid_n = sym_valid && !sym_ready;
    done_n      = 1'b0;
    din_ready   = 1'b0;
    load        = 1'b0;
    u           = 1'b0;

    unique case (state)
      IDLE: begin
        // done marks the cycle we just re-entered IDLE; a start there is dropped
        if (start && !done) begin
          state_n = DATA;
          sr_n    = '0;
          cnt_n   = '0;
        end
      end
      DATA: begin
        din_ready = slot_free;
        if (din_valid && slot_free) begin
          load = 1'b1;
          u    = din;
          if (cnt == LAST_BIT) begin
            state_n = TAIL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          load = 1'b1;
          if (cnt == LAST_TAIL) begin
            state_n = FLUSH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (sym_valid && sym_ready) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      sym_n       = {u ^ sr[1] ^ sr[2], u ^ sr[0] ^ sr[1] ^ sr[2]};
      sym_valid_n = 1'b1;
      sr_n        = {sr[1:0], u};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      sym       <= '0;
      sym_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      sym       <= sym_n;
      sym_valid <= sym_valid_n;
      done      <= done_n;
    end
  end

endmodule
